fp_add_initiator: RTL and testbench

FP_ADD_INITIATOR -- requirements
Module: fp_add_initiator

---
 rtl/fp_add_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_fp_add_initiator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_initiator.sv
// fp_add_initiator
// Accepts one IEEE-754 single operand pair from upstream, pushes A then B
// into a strobe/ack floating-point adder, collects the sum and presents it
// downstream on a valid/ready response port.
//
// Optional build macro: FP_ADD_INITIATOR_TIMEOUT_EN
//   defined   - each adder phase (SEND_A, SEND_B, WAIT_Z) is bounded by
//               TIMEOUT_CYCLES; on expiry the initiator responds with
//               resp_err=1 and resp_z=32'h7FC00000 (quiet NaN).
//   undefined - the initiator waits indefinitely in each phase and
//               resp_err is constant 0.
//
// Handshake rules (both the request/response side and the adder side):
//   A transfer happens on a rising clk edge where the producer's valid/stb
//   and the consumer's ready/ack are both high. Every handshake output is a
//   pure decode of the state register, so no input reaches an output
//   combinationally; a strobe drops in the cycle after its transfer because
//   the state has moved on. add_z_ack is also high in IDLE and SEND_A so a
//   stale result left in the adder is drained and thrown away.

module fp_add_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // upstream request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  // downstream response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_z,
  output logic        resp_err,
  output logic [15:0] txn_count,
  // adder operand side
  output logic [31:0] add_a,
  output logic        add_a_stb,
  input  logic        add_a_ack,
  output logic [31:0] add_b,
  output logic        add_b_stb,
  input  logic        add_b_ack,
  // adder result side
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack,
  // debug view of the FSM state
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [31:0] ABORT_Z = 32'h7FC0_0000;

  state_t      state;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] resp_z_q;
  logic [15:0] txn_count_q;

  // Transfer qualifiers, only meaningful in their own state.
  logic req_xfer;
  logic a_xfer;
  logic b_xfer;
  logic z_xfer;
  logic resp_xfer;

  assign req_xfer  = (state == IDLE)   && req_valid;
  assign a_xfer    = (state == SEND_A) && add_a_ack;
  assign b_xfer    = (state == SEND_B) && add_b_ack;
  assign z_xfer    = (state == WAIT_Z) && add_z_stb;
  assign resp_xfer = (state == RESP)   && resp_ready;

`ifdef FP_ADD_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;
  logic        resp_err_q;
  logic        in_phase;
  logic        phase_xfer;
  logic        to_hit;

  // A "phase" is any state that waits on the adder.
  assign in_phase   = (state == SEND_A) || (state == SEND_B) || (state == WAIT_Z);
  assign phase_xfer = a_xfer || b_xfer || z_xfer;
  assign to_hit     = in_phase && !phase_xfer && (to_cnt_q == TO_LAST);

  // Phase counter: cleared on every phase entry, counts idle cycles inside a phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= 16'd0;
    end else if (req_xfer || a_xfer || b_xfer) begin
      to_cnt_q <= 16'd0;
    end else if (in_phase && !phase_xfer && !to_hit) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end else if (!in_phase) begin
      to_cnt_q <= 16'd0;
    end
  end

  // Error flag: set by a timeout abort, cleared by a real adder result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_q <= 1'b0;
    end else if (z_xfer) begin
      resp_err_q <= 1'b0;
    end else if (to_hit) begin
      resp_err_q <= 1'b1;
    end
  end

  assign resp_err = resp_err_q;
`else
  logic to_hit;

  assign to_hit   = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Main FSM: walks one transaction through the adder handshake phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_xfer) state <= SEND_A;
        end
        SEND_A: begin
          if (a_xfer)      state <= SEND_B;
          else if (to_hit) state <= RESP;
        end
        SEND_B: begin
          if (b_xfer)      state <= WAIT_Z;
          else if (to_hit) state <= RESP;
        end
        WAIT_Z: begin
          if (z_xfer)      state <= RESP;
          else if (to_hit) state <= RESP;
        end
        RESP: begin
          if (resp_xfer) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers: captured once at request acceptance and held stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q <= 32'd0;
      op_b_q <= 32'd0;
    end else if (req_xfer) begin
      op_a_q <= req_a;
      op_b_q <= req_b;
    end
  end

  // Result register: adder sum on a real transfer, abort pattern on timeout.
  // Drained results in IDLE/SEND_A never reach here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_z_q <= 32'd0;
    end else if (z_xfer) begin
      resp_z_q <= add_z;
    end else if (to_hit) begin
      resp_z_q <= ABORT_Z;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= 16'd0;
    end else if (resp_xfer) begin
      txn_count_q <= txn_count_q + 16'd1;
    end
  end

  // Output decode from the state register only.
  assign req_ready  = (state == IDLE);
  assign add_a_stb  = (state == SEND_A);
  assign add_b_stb  = (state == SEND_B);
  assign add_z_ack  = (state == IDLE) || (state == SEND_A) || (state == WAIT_Z);
  assign resp_valid = (state == RESP);
  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign resp_z     = resp_z_q;
  assign txn_count  = txn_count_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_fp_add_initiator.sv
// Directed testbench for fp_add_initiator. The bench plays both the upstream
// requester and the adder; adder results come from hand-computed vectors.
// Build with FP_ADD_INITIATOR_TIMEOUT_EN defined to also exercise the abort path.

`timescale 1ns/1ps

module tb_fp_add_initiator;

  localparam int TO_CYC = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_z;
  logic        resp_err;
  logic [15:0] txn_count;
  logic [31:0] add_a;
  logic        add_a_stb;
  logic        add_a_ack;
  logic [31:0] add_b;
  logic        add_b_stb;
  logic        add_b_ack;
  logic [31:0] add_z;
  logic        add_z_stb;
  logic        add_z_ack;
  logic [2:0]  state_dbg;

  int          n_cmp;
  int          n_err;
  logic [15:0] exp_cnt;
  logic [31:0] last_z;

  fp_add_initiator #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_z     (resp_z),
    .resp_err   (resp_err),
    .txn_count  (txn_count),
    .add_a      (add_a),
    .add_a_stb  (add_a_stb),
    .add_a_ack  (add_a_ack),
    .add_b      (add_b),
    .add_b_stb  (add_b_stb),
    .add_b_ack  (add_b_ack),
    .add_z      (add_z),
    .add_z_stb  (add_z_stb),
    .add_z_ack  (add_z_ack),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single checking task: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction with a cooperating adder.
  // a_dly: cycles SEND_A waits before ack; z_dly: cycles before result;
  // hold: cycles resp_ready is held low in RESP.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                         input int a_dly, input int z_dly, input int hold);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hDEAD_BEEF;
    check("send_a_stb", {31'd0, add_a_stb}, 32'd1);
    check("send_a_val", add_a, a);
    check("busy_no_ready", {31'd0, req_ready}, 32'd0);
    repeat (a_dly) @(negedge clk);
    if (a_dly > 0) begin
      check("a_stb_hold", {31'd0, add_a_stb}, 32'd1);
      check("a_val_hold", add_a, a);
      check("no_early_resp", {31'd0, resp_valid}, 32'd0);
    end
    add_a_ack = 1'b1;
    @(negedge clk);
    add_a_ack = 1'b0;
    check("a_stb_drop", {31'd0, add_a_stb}, 32'd0);
    check("send_b_stb", {31'd0, add_b_stb}, 32'd1);
    check("send_b_val", add_b, b);
    add_b_ack = 1'b1;
    @(negedge clk);
    add_b_ack = 1'b0;
    check("b_stb_drop", {31'd0, add_b_stb}, 32'd0);
    check("wait_z_ack", {31'd0, add_z_ack}, 32'd1);
    repeat (z_dly) @(negedge clk);
    add_z     = z;
    add_z_stb = 1'b1;
    @(negedge clk);
    add_z_stb = 1'b0;
    add_z     = 32'h0;
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_z", resp_z, z);
    check("resp_err", {31'd0, resp_err}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_z", resp_z, z);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    last_z  = z;
    check("resp_done", {31'd0, resp_valid}, 32'd0);
    check("txn_count", {16'd0, txn_count}, {16'd0, exp_cnt});
    check("back_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    exp_cnt    = 16'd0;
    last_z     = 32'd0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    add_a_ack  = 1'b0;
    add_b_ack  = 1'b0;
    add_z      = 32'd0;
    add_z_stb  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_z", resp_z, 32'd0);
    check("rst_txn_count", {16'd0, txn_count}, 32'd0);
    check("rst_a_stb", {31'd0, add_a_stb}, 32'd0);
    check("rst_b_stb", {31'd0, add_b_stb}, 32'd0);
    check("rst_z_ack", {31'd0, add_z_ack}, 32'd1);
    rst = 1'b0;

    // 1.0 + 2.0 = 3.0, back-to-back timing
    run_txn(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 0);
    // 1.0 + 1.0 = 2.0, slow adder, downstream stalls 5 cycles
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1, 2, 5);
    // 2.5 + -0.5 = 2.0
    run_txn(32'h4020_0000, 32'hBF00_0000, 32'h4000_0000, 2, 0, 1);
    // -3.0 + 3.0 = +0.0
    run_txn(32'hC040_0000, 32'h4040_0000, 32'h0000_0000, 0, 3, 0);

    // Stale result while IDLE is drained and disturbs nothing
    @(negedge clk);
    add_z     = 32'h1234_5678;
    add_z_stb = 1'b1;
    @(negedge clk);
    add_z_stb = 1'b0;
    add_z     = 32'd0;
    check("stale_still_idle", {31'd0, req_ready}, 32'd1);
    check("stale_no_valid", {31'd0, resp_valid}, 32'd0);
    check("stale_z_kept", resp_z, last_z);
    check("stale_count_kept", {16'd0, txn_count}, {16'd0, exp_cnt});
    // inf + 1.0 = inf, must return its own sum
    run_txn(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 0, 0, 0);

`ifdef FP_ADD_INITIATOR_TIMEOUT_EN
    // Adder never acks A: abort 16 cycles after SEND_A entry
    begin
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 32'h3F80_0000;
      req_b     = 32'h3F80_0000;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("to_latency", n, TO_CYC);
      check("to_valid", {31'd0, resp_valid}, 32'd1);
      check("to_err", {31'd0, resp_err}, 32'd1);
      check("to_z", resp_z, 32'h7FC0_0000);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      check("to_count", {16'd0, txn_count}, {16'd0, exp_cnt});
      // next normal result clears the error flag (checked inside run_txn)
      run_txn(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0, 0, 0);
    end
`else
    // No timeout: the initiator keeps waiting on a silent adder
    run_txn(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 40, 0, 0);
`endif

    // Counter wrap: preload 0xFFFF, one more completion wraps to 0
    @(negedge clk);
    force dut.txn_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    check("preload_count", {16'd0, txn_count}, 32'h0000_FFFF);
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0);
    check("wrap_count", {16'd0, txn_count}, 32'h0000_0000);

    // Asynchronous reset while waiting for the result
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 32'h3F80_0000;
    req_b     = 32'h4000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    add_a_ack = 1'b1;
    @(negedge clk);
    add_a_ack = 1'b0;
    add_b_ack = 1'b1;
    @(negedge clk);
    add_b_ack = 1'b0;
    check("pre_rst_wait_z", {29'd0, state_dbg}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_resp_z", resp_z, 32'd0);
    check("arst_txn_count", {16'd0, txn_count}, 32'd0);
    check("arst_a_stb", {31'd0, add_a_stb}, 32'd0);
    check("arst_b_stb", {31'd0, add_b_stb}, 32'd0);
    check("arst_z_ack", {31'd0, add_z_ack}, 32'd1);
    check("arst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = 16'd0;
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
